// File: rtl/axi_rdata_strb_pipe.sv
// AXI R-channel post-processor: tracks multi-burst transfers from queued descriptors,
// generates first/last-beat byte strobes and registers the data path through a 2-entry skid buffer.
module axi_rdata_strb_pipe #(
    parameter int AXI_IDW      = 4,
    parameter int AXI_DATA_WID = 256,
    parameter int AXI_STRBW    = AXI_DATA_WID / 8,
    parameter int OFFW         = $clog2(AXI_STRBW),
    parameter int DESC_DEPTH   = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    desc_valid,
    output logic                    desc_ready,
    input  logic [OFFW-1:0]         desc_first_off,
    input  logic [OFFW-1:0]         desc_last_bytes,
    input  logic [15:0]             desc_nburst,
    input  logic                    i_rvalid,
    input  logic                    i_rlast,
    input  logic [AXI_DATA_WID-1:0] i_rdata,
    input  logic [AXI_IDW-1:0]      i_rid,
    input  logic [1:0]              i_rresp,
    output logic                    o_rready,
    output logic                    o_dvalid,
    input  logic                    i_dready,
    output logic [AXI_DATA_WID-1:0] o_ddata,
    output logic [AXI_STRBW-1:0]    o_dstrb,
    output logic                    o_dlast,
    output logic                    o_burst_done,
    output logic                    o_xfer_done,
    output logic                    o_err,
    output logic [1:0]              o_err_resp,
    output logic [AXI_IDW-1:0]      o_err_id,
    input  logic                    i_err_clr
);

    localparam int DPW = $clog2(DESC_DEPTH);
    localparam logic [DPW:0]           DQ_INC    = {{DPW{1'b0}}, 1'b1};
    localparam logic [AXI_STRBW-1:0]   STRB_ONES = {AXI_STRBW{1'b1}};
    localparam logic [AXI_STRBW-1:0]   STRB_LSB  = {{(AXI_STRBW-1){1'b0}}, 1'b1};

    logic [OFFW-1:0] dq_off [DESC_DEPTH];
    logic [OFFW-1:0] dq_lb  [DESC_DEPTH];
    logic [15:0]     dq_nb  [DESC_DEPTH];
    logic [DPW:0]    dq_wr, dq_rd;
    logic            dq_full, head_valid, desc_push, desc_pop;

    logic [OFFW-1:0] h_off, h_lb;
    logic [15:0]     h_nb, h_nb_m1, burst_cnt;
    logic            first_pend, accept, beat_last;
    logic [AXI_STRBW-1:0] first_mask, last_mask, beat_strb;

    logic [AXI_DATA_WID-1:0] sk_data [2];
    logic [AXI_STRBW-1:0]    sk_strb [2];
    logic                    sk_last [2];
    logic [1:0]              skid_cnt;
    logic                    sk_wr, sk_rd, skid_pop;

    // Extra pointer bit distinguishes full from empty without a separate counter.
    assign dq_full    = (dq_wr[DPW] != dq_rd[DPW]) && (dq_wr[DPW-1:0] == dq_rd[DPW-1:0]);
    assign head_valid = (dq_wr != dq_rd);
    assign desc_ready = !dq_full;
    assign desc_push  = desc_valid && !dq_full;

    // NOTE: descriptor entries are not reset because the pointers alone define occupancy;
    // the skid entries further down are, since they drive the outputs directly.
    always_ff @(posedge aclk) begin
        if (desc_push) begin
            dq_off[dq_wr[DPW-1:0]] <= desc_first_off;
            dq_lb[dq_wr[DPW-1:0]]  <= desc_last_bytes;
            dq_nb[dq_wr[DPW-1:0]]  <= desc_nburst;
        end
    end

    assign h_off   = dq_off[dq_rd[DPW-1:0]];
    assign h_lb    = dq_lb[dq_rd[DPW-1:0]];
    assign h_nb    = dq_nb[dq_rd[DPW-1:0]];
    assign h_nb_m1 = (h_nb == 16'd0) ? 16'd0 : h_nb - 16'd1;

    assign o_rready  = head_valid && (skid_cnt != 2'd2);
    assign accept    = i_rvalid && o_rready;
    assign beat_last = i_rlast && (burst_cnt == h_nb_m1);
    assign desc_pop  = accept && beat_last;
    assign o_dvalid  = (skid_cnt != 2'd0);
    assign skid_pop  = o_dvalid && i_dready;

    always_comb begin
        first_mask = STRB_ONES << h_off;
        last_mask  = (h_lb == '0) ? STRB_ONES : (STRB_LSB << h_lb) - STRB_LSB;
        beat_strb  = STRB_ONES;
        if (first_pend) beat_strb = beat_strb & first_mask;
        if (beat_last)  beat_strb = beat_strb & last_mask;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dq_wr        <= '0;
            dq_rd        <= '0;
            burst_cnt    <= '0;
            first_pend   <= 1'b1;
            o_burst_done <= 1'b0;
            o_xfer_done  <= 1'b0;
        end else begin
            if (desc_push) dq_wr <= dq_wr + DQ_INC;
            if (desc_pop)  dq_rd <= dq_rd + DQ_INC;
            if (accept && i_rlast) burst_cnt <= beat_last ? 16'd0 : burst_cnt + 16'd1;
            // A pop re-arms the first-beat mask for the next descriptor.
            if (accept) first_pend <= beat_last;
            o_burst_done <= accept && i_rlast;
            o_xfer_done  <= desc_pop;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            skid_cnt <= 2'd0;
            sk_wr    <= 1'b0;
            sk_rd    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                sk_data[i] <= '0;
                sk_strb[i] <= '0;
                sk_last[i] <= 1'b0;
            end
        end else begin
            if (accept) begin
                sk_data[sk_wr] <= i_rdata;
                sk_strb[sk_wr] <= beat_strb;
                sk_last[sk_wr] <= beat_last;
                sk_wr          <= ~sk_wr;
            end
            if (skid_pop) sk_rd <= ~sk_rd;
            case ({accept, skid_pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
        end
    end

    assign o_ddata = sk_data[sk_rd];
    assign o_dstrb = sk_strb[sk_rd];
    assign o_dlast = sk_last[sk_rd];

    // A fresh error in the clearing cycle takes priority over the clear.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            o_err      <= 1'b0;
            o_err_resp <= 2'b00;
            o_err_id   <= '0;
        end else if (accept && i_rresp[1] && (!o_err || i_err_clr)) begin
            o_err      <= 1'b1;
            o_err_resp <= i_rresp;
            o_err_id   <= i_rid;
        end else if (i_err_clr) begin
            o_err      <= 1'b0;
            o_err_resp <= 2'b00;
            o_err_id   <= '0;
        end
    end

endmodule

// File: tb/tb_axi_rdata_strb_pipe.sv
// Self-checking bench for axi_rdata_strb_pipe: randomized beats scored against a
// per-byte strobe model and an expected-beat queue.
module tb_axi_rdata_strb_pipe;

    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int OW = $clog2(SW);
    localparam int IW = 4;
    localparam int DD = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          desc_valid = 1'b0;
    logic          desc_ready;
    logic [OW-1:0] desc_first_off = '0;
    logic [OW-1:0] desc_last_bytes = '0;
    logic [15:0]   desc_nburst = '0;
    logic          i_rvalid = 1'b0;
    logic          i_rlast = 1'b0;
    logic [DW-1:0] i_rdata = '0;
    logic [IW-1:0] i_rid = '0;
    logic [1:0]    i_rresp = '0;
    logic          o_rready;
    logic          o_dvalid;
    logic          i_dready = 1'b1;
    logic [DW-1:0] o_ddata;
    logic [SW-1:0] o_dstrb;
    logic          o_dlast;
    logic          o_burst_done;
    logic          o_xfer_done;
    logic          o_err;
    logic [1:0]    o_err_resp;
    logic [IW-1:0] o_err_id;
    logic          i_err_clr = 1'b0;

    int    checks = 0;
    int    errors = 0;
    int    bd_cnt = 0;
    int    xd_cnt = 0;
    int    out_cnt = 0;
    bit    ready_rand = 1'b0;
    bit    ready_val = 1'b1;
    beat_t exp_q[$];
    beat_t mon_e;

    axi_rdata_strb_pipe #(
        .AXI_IDW(IW), .AXI_DATA_WID(DW), .AXI_STRBW(SW), .OFFW(OW), .DESC_DEPTH(DD)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_first_off(desc_first_off), .desc_last_bytes(desc_last_bytes),
        .desc_nburst(desc_nburst),
        .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rdata(i_rdata), .i_rid(i_rid),
        .i_rresp(i_rresp), .o_rready(o_rready),
        .o_dvalid(o_dvalid), .i_dready(i_dready), .o_ddata(o_ddata), .o_dstrb(o_dstrb),
        .o_dlast(o_dlast), .o_burst_done(o_burst_done), .o_xfer_done(o_xfer_done),
        .o_err(o_err), .o_err_resp(o_err_resp), .o_err_id(o_err_id), .i_err_clr(i_err_clr)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        #2;
        i_dready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // Byte b of beat idx is valid unless it lies before the first offset (first beat)
    // or at/after the last-beat byte count (last beat, nonzero count).
    function automatic logic [SW-1:0] model_strb(input int idx, input int total,
                                                 input int off, input int lb);
        logic [SW-1:0] s;
        for (int b = 0; b < SW; b++) begin
            s[b] = 1'b1;
            if (idx == 0 && b < off) s[b] = 1'b0;
            if (idx == total - 1 && lb != 0 && b >= lb) s[b] = 1'b0;
        end
        return s;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    always @(negedge aclk) begin
        if (aresetn) begin
            if (o_burst_done) bd_cnt++;
            if (o_xfer_done)  xd_cnt++;
            if (o_dvalid && i_dready) begin
                checks++;
                out_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat unexpected: strb=%h last=%b data=%h", o_dstrb, o_dlast, o_ddata);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (o_ddata !== mon_e.data || o_dstrb !== mon_e.strb || o_dlast !== mon_e.last) begin
                        errors++;
                        $display("FAIL out_beat: got strb=%h last=%b data=%h, want strb=%h last=%b data=%h",
                                 o_dstrb, o_dlast, o_ddata, mon_e.strb, mon_e.last, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_desc(input int off, input int lb, input int nb);
        bit ok = 1'b0;
        desc_first_off  = OW'(off);
        desc_last_bytes = OW'(lb);
        desc_nburst     = 16'(nb);
        desc_valid      = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge aclk);
            ok = desc_ready;
            @(posedge aclk);
            #1;
            if (ok) break;
        end
        desc_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL desc_push timeout: desc_ready=%b want 1", desc_ready);
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic [1:0] resp,
                             input logic [IW-1:0] id, input logic [SW-1:0] es,
                             input logic el, input logic clr);
        bit acc = 1'b0;
        i_rvalid  = 1'b1;
        i_rdata   = d;
        i_rlast   = last;
        i_rresp   = resp;
        i_rid     = id;
        i_err_clr = clr;
        for (int n = 0; n < 200; n++) begin
            @(negedge aclk);
            acc = o_rready;
            @(posedge aclk);
            #1;
            if (acc) break;
        end
        i_rvalid  = 1'b0;
        i_err_clr = 1'b0;
        if (acc) exp_q.push_back('{d, es, el});
        else begin
            checks++;
            errors++;
            $display("FAIL beat_accept timeout: o_rready=%b want 1", o_rready);
        end
    endtask

    task automatic send_xfer(input int off, input int lb, input int nb, input int lens[4]);
        int nreal = (nb == 0) ? 1 : nb;
        int total = 0;
        int idx = 0;
        for (int b = 0; b < nreal; b++) total += lens[b];
        for (int b = 0; b < nreal; b++)
            for (int j = 0; j < lens[b]; j++) begin
                send_beat(rand_data(), j == lens[b] - 1, 2'b00, IW'(b),
                          model_strb(idx, total, off, lb), idx == total - 1, 1'b0);
                idx++;
            end
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge aclk);
            if (exp_q.size() == 0 && !o_dvalid) begin
                done = 1'b1;
                break;
            end
        end
        @(posedge aclk);
        #1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s drain: %0d beats still expected", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge aclk);
        #1;
        checks += 2;
        if ({desc_ready, o_rready, o_dvalid, o_dlast, o_burst_done, o_xfer_done, o_err,
             o_err_resp, o_err_id} !== {1'b1, 12'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b rready=%b dvalid=%b err=%b resp=%0d id=%0d",
                     desc_ready, o_rready, o_dvalid, o_err, o_err_resp, o_err_id);
        end
        if (o_dstrb !== '0 || o_ddata !== '0) begin
            errors++;
            $display("FAIL reset_data: got strb=%h data=%h want 0", o_dstrb, o_ddata);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        checks++;
        if (desc_ready !== 1'b1 || o_rready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: desc_ready=%b o_rready=%b want 1/0", desc_ready, o_rready);
        end
    endtask

    task automatic test_unaligned();
        int bd0 = bd_cnt;
        int xd0 = xd_cnt;
        push_desc(5, 3, 2);
        send_xfer(5, 3, 2, '{4, 4, 0, 0});
        drain("unaligned");
        checks += 2;
        if (bd_cnt - bd0 != 2) begin
            errors++;
            $display("FAIL unaligned_burst_done: got %0d pulses want 2", bd_cnt - bd0);
        end
        if (xd_cnt - xd0 != 1) begin
            errors++;
            $display("FAIL unaligned_xfer_done: got %0d pulses want 1", xd_cnt - xd0);
        end
    endtask

    task automatic test_single();
        int xd0 = xd_cnt;
        push_desc(2, 6, 1);
        send_xfer(2, 6, 1, '{1, 0, 0, 0});
        drain("single");
        checks++;
        if (xd_cnt - xd0 != 1) begin
            errors++;
            $display("FAIL single_xfer_done: got %0d pulses want 1", xd_cnt - xd0);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] bd [4];
        int rdy_seen = 0;
        int out0;
        for (int i = 0; i < 4; i++) bd[i] = rand_data();
        ready_val = 1'b0;
        @(posedge aclk);
        #1;
        out0 = out_cnt;
        push_desc(4, 8, 1);
        send_beat(bd[0], 1'b0, 2'b00, 4'd1, model_strb(0, 4, 4, 8), 1'b0, 1'b0);
        send_beat(bd[1], 1'b0, 2'b00, 4'd1, model_strb(1, 4, 4, 8), 1'b0, 1'b0);
        i_rvalid = 1'b1;
        i_rdata  = bd[2];
        i_rlast  = 1'b0;
        repeat (6) begin
            @(negedge aclk);
            if (o_rready) rdy_seen++;
        end
        checks += 2;
        if (rdy_seen != 0 || o_dvalid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall: o_rready high %0d cycles, o_dvalid=%b; want 0 and 1", rdy_seen, o_dvalid);
        end
        if (out_cnt != out0) begin
            errors++;
            $display("FAIL bp_hold: %0d beats left while i_dready low, want 0", out_cnt - out0);
        end
        @(posedge aclk);
        #1;
        ready_val = 1'b1;
        send_beat(bd[2], 1'b0, 2'b00, 4'd1, model_strb(2, 4, 4, 8), 1'b0, 1'b0);
        send_beat(bd[3], 1'b1, 2'b00, 4'd1, model_strb(3, 4, 4, 8), 1'b1, 1'b0);
        drain("backpressure");
        checks++;
        if (out_cnt - out0 != 4) begin
            errors++;
            $display("FAIL bp_count: got %0d beats want 4", out_cnt - out0);
        end
    endtask

    task automatic test_no_desc();
        logic [DW-1:0] d = rand_data();
        int rdy_seen = 0;
        int lat = 99;
        bit acc;
        i_rvalid = 1'b1;
        i_rdata  = d;
        i_rlast  = 1'b1;
        i_rresp  = 2'b00;
        repeat (4) begin
            @(negedge aclk);
            if (o_rready) rdy_seen++;
        end
        checks++;
        if (rdy_seen != 0) begin
            errors++;
            $display("FAIL nodesc_stall: o_rready high %0d cycles want 0", rdy_seen);
        end
        @(posedge aclk);
        #1;
        desc_first_off  = '0;
        desc_last_bytes = '0;
        desc_nburst     = 16'd1;
        desc_valid      = 1'b1;
        @(posedge aclk);
        #1;
        desc_valid = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge aclk);
            acc = o_rready;
            @(posedge aclk);
            #1;
            if (acc) begin
                lat = n;
                break;
            end
        end
        i_rvalid = 1'b0;
        if (lat <= 4) exp_q.push_back('{d, {SW{1'b1}}, 1'b1});
        checks++;
        if (lat > 2) begin
            errors++;
            $display("FAIL nodesc_latency: accepted after %0d cycles want <=2", lat);
        end
        drain("no_desc");
    endtask

    task automatic test_errors();
        bit seen = 1'b0;
        push_desc(0, 0, 1);
        send_beat(rand_data(), 1'b0, 2'b00, 4'd1, {SW{1'b1}}, 1'b0, 1'b0);
        send_beat(rand_data(), 1'b0, 2'b10, 4'd3, {SW{1'b1}}, 1'b0, 1'b0);
        send_beat(rand_data(), 1'b0, 2'b11, 4'd5, {SW{1'b1}}, 1'b0, 1'b0);
        send_beat(rand_data(), 1'b1, 2'b00, 4'd1, {SW{1'b1}}, 1'b1, 1'b0);
        drain("errors");
        checks++;
        if (o_err !== 1'b1 || o_err_resp !== 2'd2 || o_err_id !== 4'd3) begin
            errors++;
            $display("FAIL err_capture: got err=%b resp=%0d id=%0d want 1/2/3", o_err, o_err_resp, o_err_id);
        end
        push_desc(0, 0, 1);
        for (int n = 0; n < 20; n++) begin
            @(negedge aclk);
            if (o_rready) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge aclk);
        #1;
        send_beat(rand_data(), 1'b1, 2'b11, 4'd7, {SW{1'b1}}, 1'b1, 1'b1);
        checks++;
        if (!seen || o_err !== 1'b1 || o_err_resp !== 2'd3 || o_err_id !== 4'd7) begin
            errors++;
            $display("FAIL err_clr_new: got err=%b resp=%0d id=%0d want 1/3/7", o_err, o_err_resp, o_err_id);
        end
        drain("err_clr");
    endtask

    task automatic test_back_to_back();
        int la [4];
        int lb_ [4];
        int oa, ob, na, nb, ea, eb;
        int bd0 = bd_cnt;
        int xd0 = xd_cnt;
        int exp_bd = 0;
        ready_rand = 1'b1;
        for (int t = 0; t < 6; t++) begin
            oa = $urandom_range(0, SW - 1);
            ea = $urandom_range(0, SW - 1);
            na = $urandom_range(0, 3);
            ob = $urandom_range(0, SW - 1);
            eb = $urandom_range(0, SW - 1);
            nb = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) begin
                la[i]  = $urandom_range(1, 4);
                lb_[i] = $urandom_range(1, 4);
            end
            exp_bd += ((na == 0) ? 1 : na) + ((nb == 0) ? 1 : nb);
            push_desc(oa, ea, na);
            push_desc(ob, eb, nb);
            send_xfer(oa, ea, na, la);
            send_xfer(ob, eb, nb, lb_);
        end
        drain("back_to_back");
        ready_rand = 1'b0;
        checks += 2;
        if (bd_cnt - bd0 != exp_bd) begin
            errors++;
            $display("FAIL b2b_burst_done: got %0d want %0d", bd_cnt - bd0, exp_bd);
        end
        if (xd_cnt - xd0 != 12) begin
            errors++;
            $display("FAIL b2b_xfer_done: got %0d want 12", xd_cnt - xd0);
        end
    endtask

    task automatic test_desc_full_reset();
        ready_val = 1'b0;
        for (int i = 0; i < DD; i++) push_desc(1, 1, 2);
        checks++;
        if (desc_ready !== 1'b0) begin
            errors++;
            $display("FAIL desc_full: desc_ready=%b want 0", desc_ready);
        end
        send_beat(rand_data(), 1'b0, 2'b00, 4'd2, model_strb(0, 2, 1, 1), 1'b0, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        exp_q.delete();
        checks += 2;
        if ({desc_ready, o_rready, o_dvalid, o_dlast, o_burst_done, o_xfer_done, o_err,
             o_err_resp, o_err_id} !== {1'b1, 12'b0}) begin
            errors++;
            $display("FAIL midreset_ctrl: got rdy=%b rready=%b dvalid=%b err=%b resp=%0d id=%0d",
                     desc_ready, o_rready, o_dvalid, o_err, o_err_resp, o_err_id);
        end
        if (o_dstrb !== '0 || o_ddata !== '0) begin
            errors++;
            $display("FAIL midreset_data: got strb=%h data=%h want 0", o_dstrb, o_ddata);
        end
        ready_val = 1'b1;
        repeat (2) @(posedge aclk);
        #3;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        checks++;
        if (o_rready !== 1'b0 || o_dvalid !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: o_rready=%b o_dvalid=%b want 0/0", o_rready, o_dvalid);
        end
        push_desc(3, 0, 1);
        send_xfer(3, 0, 1, '{2, 0, 0, 0});
        drain("after_reset");
    endtask

    initial begin
        test_reset();
        test_unaligned();
        test_single();
        test_backpressure();
        test_no_desc();
        test_errors();
        test_back_to_back();
        test_desc_full_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
